ahb_cfg_default_slave: RTL

- Parametrised default slave for the AHB bus matrix; answers every transfer that decodes to no real slave.
- Adds programmable wait states, selectable ERROR/OKAY response mode, a sticky fault-address log and a saturating fault counter.
- Sits on the matrix's default-slave port; log and counter outputs go to a debug/status register block.

---
 rtl/ahb_cfg_default_slave.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ahb_cfg_default_slave.sv
// AHB default slave: answers every transfer that decodes to no real slave.
// Programmable wait states, ERROR or OKAY response mode, a sticky fault
// address log and a saturating fault counter for the debug status block.
// Optional build macro AHB_DEFSLV_IRQ_EN adds a registered IRQ output
// raised while the log holds a capture or an overflow.
module ahb_cfg_default_slave #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          WAIT_STATES = 0,
    parameter int          RESP_MODE   = 0,
    parameter logic [31:0] RDATA_VALUE = 32'hDEADBEEF,
    parameter int          CNT_WIDTH   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  LOG_CLR,
    output logic                  LOG_VALID,
    output logic                  LOG_OVF,
    output logic [ADDR_WIDTH-1:0] LOG_ADDR,
    output logic                  LOG_WRITE,
`ifdef AHB_DEFSLV_IRQ_EN
    output logic                  IRQ,
`endif
    output logic [CNT_WIDTH-1:0]  ERR_COUNT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2,
        ST_OKRSP
    } state_t;

    // First response state once the wait phase (if any) is over
    localparam state_t RESP_STATE  = (RESP_MODE == 1) ? ST_OKRSP : ST_ERR1;
    localparam state_t START_STATE = (WAIT_STATES > 0) ? ST_WAIT : RESP_STATE;
    localparam logic [3:0] WCNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [DATA_WIDTH-1:0] RDATA_EXT = DATA_WIDTH'(RDATA_VALUE);

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [3:0]             r_wcnt;
    logic [3:0]             w_wcntNext;
    logic                   r_wasWrite;
    logic                   r_logValid;
    logic                   r_logOvf;
    logic [ADDR_WIDTH-1:0]  r_logAddr;
    logic                   r_logWrite;
    logic [CNT_WIDTH-1:0]   r_errCount;
    logic                   w_acc;
    logic                   w_canAccept;
    logic                   w_start;
    logic                   w_unusedTrans;

    // Only NONSEQ/SEQ matter; HTRANS[0] just separates IDLE from BUSY
    assign w_unusedTrans = HTRANS[0];
    assign w_acc         = HSEL & HREADY & HTRANS[1];
    assign w_canAccept   = (r_state == ST_IDLE) || (r_state == ST_ERR2) || (r_state == ST_OKRSP);
    assign w_start       = w_acc & w_canAccept;

    // Next-state and bus outputs, decoded purely from the current state
    always_comb begin
        w_stateNext = r_state;
        w_wcntNext  = r_wcnt;
        HREADYOUT   = 1'b1;
        HRESP       = 2'b00;
        HRDATA      = '0;
        case (r_state)
            ST_IDLE: begin
                w_stateNext = ST_IDLE;
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wcnt == 4'd0) begin
                    w_stateNext = RESP_STATE;
                end else begin
                    w_wcntNext = r_wcnt - 4'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 2'b01;
                w_stateNext = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP       = 2'b01;
                w_stateNext = ST_IDLE;
            end
            ST_OKRSP: begin
                HRDATA      = r_wasWrite ? '0 : RDATA_EXT;
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
        if (w_start) begin
            w_stateNext = START_STATE;
            w_wcntNext  = WCNT_LOAD;
        end
    end

    // Bus FSM registers; direction of the accepted transfer picks OKAY read data
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wcnt     <= 4'd0;
            r_wasWrite <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_wcnt  <= w_wcntNext;
            if (w_start) begin
                r_wasWrite <= HWRITE;
            end
        end
    end

    // Fault log and saturating counter; a capture in the clear cycle wins over the clear
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_logValid <= 1'b0;
            r_logOvf   <= 1'b0;
            r_logAddr  <= '0;
            r_logWrite <= 1'b0;
            r_errCount <= '0;
        end else if (w_acc) begin
            if (LOG_CLR || !r_logValid) begin
                r_logValid <= 1'b1;
                r_logAddr  <= HADDR;
                r_logWrite <= HWRITE;
                r_logOvf   <= 1'b0;
            end else begin
                r_logOvf <= 1'b1;
            end
            if (LOG_CLR) begin
                r_errCount <= CNT_WIDTH'(1);
            end else if (r_errCount != '1) begin
                r_errCount <= r_errCount + CNT_WIDTH'(1);
            end
        end else if (LOG_CLR) begin
            r_logValid <= 1'b0;
            r_logOvf   <= 1'b0;
            r_errCount <= '0;
        end
    end

    assign LOG_VALID = r_logValid;
    assign LOG_OVF   = r_logOvf;
    assign LOG_ADDR  = r_logAddr;
    assign LOG_WRITE = r_logWrite;
    assign ERR_COUNT = r_errCount;

`ifdef AHB_DEFSLV_IRQ_EN
    logic r_irq;

    // Interrupt follows the log state one cycle later
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_logValid | r_logOvf;
        end
    end

    assign IRQ = r_irq;
`endif

endmodule
